axis_spi_master: RTL and testbench
==================================

// Module: axis_spi_master
// PURPOSE
//  SPI master, the controller end of the single-word SPI link. Each word accepted on s_axis
//  is shifted out on MOSI under a locally generated SCLK and CS frame; the word shifted in
//  on MISO during the same frame is presented on m_axis.
//  Sits between the system AXI-Stream fabric and an off-chip or on-chip SPI slave.
//  All logic runs on clk_i; SCLK is derived from clk_i, so no CDC is needed.
// PARAMETERS
//  SPI_MODE    1   0..3; CPOL = SPI_MODE[1], CPHA = SPI_MODE[0] (0:0/0 1:0/1 2:1/0 3:1/1)
//  DATA_WIDTH  8   bits per frame, MSB first, >= 2
//  CLK_DIV     4   clk_i cycles per SCLK half-period, >= 2
// PORTS
//  clk_i       in   1           system clock
//  arstn_i     in   1           asynchronous active-low reset
//  spi_clk_o   out  1           SCLK, idles at CPOL
//  spi_cs_o    out  1           chip select, active low, one frame per word
//  spi_mosi_o  out  1           master-out data
//  spi_miso_i  in   1           master-in data
//  s_axis      axis_if.slave    DATA_WIDTH tdata: word to transmit
//  m_axis      axis_if.master   DATA_WIDTH tdata: word received
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, spi_cs_o=1, spi_clk_o=CPOL, spi_mosi_o=0,
//   m_axis.tvalid=0, m_axis.tdata=0, s_axis.tready=0, all counters 0. A frame in flight is
//   abandoned; CS is released immediately.
//  FSM: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
//   IDLE : s_axis.tready = !m_axis.tvalid (registered). On handshake: tx_shift <= tdata,
//          MOSI <= tdata[MSB], go to SETUP.
//   SETUP: CS=0 for CLK_DIV cycles, SCLK=CPOL.
//   XFER : 2*DATA_WIDTH SCLK edges, one every CLK_DIV cycles; edges numbered 1..2N.
//          CPHA=0: sample MISO on odd edges 1..2N-1; shift MOSI on even edges 2..2N-2.
//          CPHA=1: shift MOSI on odd edges 3..2N-1; sample MISO on even edges 2..2N.
//          Samples enter rx_shift LSB-first into the shift, giving MSB-first order. MISO is
//          sampled in the clk_i cycle that toggles SCLK; no synchroniser.
//          After edge 2N: SCLK=CPOL. Next cycle: m_axis.tdata <= rx_shift,
//          m_axis.tvalid <= 1, go to HOLD.
//   HOLD : CS=0 for CLK_DIV cycles, then CS=1.
//   GAP  : CS=1 for CLK_DIV cycles (minimum deselect time), then IDLE.
//  Frame length with CS low = (2*DATA_WIDTH+2)*CLK_DIV cycles; 72 for defaults.
//  m_axis: tvalid holds until tready is high. Handshake clears tvalid; tdata is stable while
//   tvalid is high. Because tready is gated by !m_axis.tvalid, no rx word is ever lost.
//  Back-to-back: if s_axis.tvalid is already high on entry to IDLE and m_axis is drained,
//   the handshake occurs on the first IDLE cycle. CS is never held low across words.
//  MOSI holds its last bit through HOLD and GAP. It returns to 0 only on reset.
//  SPI_MODE, CLK_DIV and DATA_WIDTH are elaboration-time only.
// STRUCTURE
//  spi_pkg: typedef enum logic [2:0] spi_state_t {IDLE,SETUP,XFER,HOLD,GAP};
//   functions cpol(mode) and cpha(mode).
//  Sub-module spi_clk_gen (CLK_DIV, DATA_WIDTH, CPOL): half-period divider, edge counter,
//   SCLK register, and lead_stb/trail_stb/done pulses, enabled by the FSM in XFER.
//  Top level: FSM, tx/rx shift registers, AXIS registers.
// TESTING
//  1 Mode 1, loopback to axis_spi_slave (mode 1); slave preloaded 0x3C; send 0xA5 ->
//    slave m_axis=0xA5, master m_axis=0x3C; CS low exactly 72 cycles.
//  2 Repeat scenario 1 for modes 0, 2, 3 -> identical data. SCLK idle level = CPOL before
//    and after each frame; 16 SCLK edges per frame.
//  3 Hold master m_axis.tready=0 and offer 0x11 then 0x22 -> s_axis.tready stays 0 after the
//    first frame; raise tready -> 0x11 delivered, then the 0x22 frame starts.
//  4 Continuous s_axis.tvalid with words 0x01..0x04, m_axis.tready=1 -> four frames,
//    CS high >= CLK_DIV cycles between frames, rx order preserved.
//  5 Assert arstn_i low mid-XFER at edge 7 -> CS=1, SCLK=CPOL, tvalid=0 within the reset
//    cycle; the next word 0x5A after release transfers correctly.
//  6 Tie MISO=1 and send 0x00, then MISO=0 and send 0xFF -> rx 0xFF then 0x00;
//    MOSI stable at every sampling edge (checked by assertion).

Source files
------------

// File: rtl/spi_pkg.sv
// SPI master shared types: FSM states and SPI mode decode helpers.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_state_t;

  function automatic logic cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream valid/ready/data bundle.
interface axis_if #(
  parameter int W = 8
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period divider, edge counter, SCLK register and
// per-edge strobes, active only while the FSM holds en high.
module spi_clk_gen #(
  parameter int   CLK_DIV    = 4,
  parameter int   DATA_WIDTH = 8,
  parameter logic CPOL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic lead_stb,
  output logic trail_stb,
  output logic first_stb,
  output logic done
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH);

  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic              sclk_q;
  logic              stb;

  // strobe marks the clk cycle whose closing edge toggles SCLK
  assign stb       = en && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign lead_stb  = stb && !edge_cnt[0];
  assign trail_stb = stb && edge_cnt[0];
  assign first_stb = stb && (edge_cnt == '0);
  assign done      = stb && (edge_cnt == EDGE_W'(2 * DATA_WIDTH - 1));
  assign sclk      = sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk_q   <= CPOL;
    end else if (!en) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk_q   <= CPOL;
    end else if (stb) begin
      div_cnt  <= '0;
      sclk_q   <= ~sclk_q;
      edge_cnt <= done ? '0 : edge_cnt + EDGE_W'(1);
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/axis_spi_master.sv
// AXI-Stream to SPI master: one CS frame per s_axis word, the word
// shifted in on MISO during that frame is returned on m_axis.
module axis_spi_master #(
  parameter int SPI_MODE   = 1,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic   clk_i,
  input  logic   arstn_i,
  output logic   spi_clk_o,
  output logic   spi_cs_o,
  output logic   spi_mosi_o,
  input  logic   spi_miso_i,
  axis_if.slave  s_axis,
  axis_if.master m_axis
);

  import spi_pkg::*;

  localparam int   N     = DATA_WIDTH;
  localparam int   DIV_W = $clog2(CLK_DIV);
  localparam logic CPOL  = cpol(2'(SPI_MODE));
  localparam logic CPHA  = cpha(2'(SPI_MODE));

  spi_state_t       state_q, state_n;
  logic [DIV_W-1:0] cnt_q, cnt_n;
  logic             cs_q, cs_n;
  logic             mosi_q, mosi_n;
  logic [N-1:0]     tx_q, tx_n;
  logic [N-1:0]     rx_q, rx_n;
  logic             tready_q, tready_n;
  logic             mtv_q, mtv_n;
  logic [N-1:0]     mtd_q, mtd_n;

  logic sclk;
  logic lead_stb;
  logic trail_stb;
  logic first_stb;
  logic done;
  logic cnt_last;
  logic sample;
  logic shift;

  spi_clk_gen #(
    .CLK_DIV    (CLK_DIV),
    .DATA_WIDTH (DATA_WIDTH),
    .CPOL       (CPOL)
  ) u_clk_gen (
    .clk       (clk_i),
    .rst_n     (arstn_i),
    .en        (state_q == XFER),
    .sclk      (sclk),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .first_stb (first_stb),
    .done      (done)
  );

  assign cnt_last = (cnt_q == DIV_W'(CLK_DIV - 1));
  assign sample   = CPHA ? trail_stb : lead_stb;
  assign shift    = CPHA ? (lead_stb && !first_stb)
                         : (trail_stb && !done);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      tready_q <= 1'b0;
      mtv_q    <= 1'b0;
      mtd_q    <= '0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      cs_q     <= cs_n;
      mosi_q   <= mosi_n;
      tx_q     <= tx_n;
      rx_q     <= rx_n;
      tready_q <= tready_n;
      mtv_q    <= mtv_n;
      mtd_q    <= mtd_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    cs_n    = cs_q;
    mosi_n  = mosi_q;
    tx_n    = tx_q;
    rx_n    = rx_q;
    mtv_n   = mtv_q;
    mtd_n   = mtd_q;

    if (mtv_q && m_axis.tready) begin
      mtv_n = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (s_axis.tvalid && tready_q) begin
          tx_n    = s_axis.tdata;
          mosi_n  = s_axis.tdata[N-1];
          cs_n    = 1'b0;
          cnt_n   = '0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (cnt_last) begin
          cnt_n   = '0;
          state_n = XFER;
        end else begin
          cnt_n = cnt_q + DIV_W'(1);
        end
      end
      XFER: begin
        if (sample) begin
          rx_n = {rx_q[N-2:0], spi_miso_i};
        end
        if (shift) begin
          tx_n   = tx_q << 1;
          mosi_n = tx_q[N-2];
        end
        // last edge may also carry the last sample, so publish rx_n
        if (done) begin
          mtd_n   = rx_n;
          mtv_n   = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (cnt_last) begin
          cnt_n   = '0;
          cs_n    = 1'b1;
          state_n = GAP;
        end else begin
          cnt_n = cnt_q + DIV_W'(1);
        end
      end
      GAP: begin
        if (cnt_last) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // ready is only offered in IDLE with the rx slot empty
    tready_n = (state_n == IDLE) && !mtv_n;
  end

  assign spi_clk_o     = sclk;
  assign spi_cs_o      = cs_q;
  assign spi_mosi_o    = mosi_q;
  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = mtv_q;
  assign m_axis.tdata  = mtd_q;

endmodule

// File: tb/tb_axis_spi_master.sv
// Bench for axis_spi_master: all four SPI modes run in lockstep, each
// against a behavioural SPI slave, with queued expectations.
module tb_axis_spi_master;

  localparam int N     = 8;
  localparam int DIV   = 4;
  localparam int FRAME = (2 * N + 2) * DIV;
  localparam int BUD   = 400;

  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  logic       s_tvalid;
  logic [7:0] s_tdata;
  logic       m_tready;
  logic       tie_en;
  logic       tie_val;

  logic       s_tready [4];
  logic       m_tvalid [4];
  logic [7:0] m_tdata  [4];
  logic       sclk     [4];
  logic       cs       [4];
  logic       mosi     [4];
  logic       miso     [4];

  logic [7:0] exp_m [4][$];
  logic [7:0] exp_s [4][$];
  logic [7:0] stx_q [4][$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam logic POL = (g / 2) == 1;
    localparam logic PHA = (g % 2) == 1;

    axis_if #(.W(8)) s_if ();
    axis_if #(.W(8)) m_if ();

    assign s_if.tvalid = s_tvalid;
    assign s_if.tdata  = s_tdata;
    assign m_if.tready = m_tready;
    assign s_tready[g] = s_if.tready;
    assign m_tvalid[g] = m_if.tvalid;
    assign m_tdata[g]  = m_if.tdata;

    axis_spi_master #(
      .SPI_MODE   (g),
      .DATA_WIDTH (N),
      .CLK_DIV    (DIV)
    ) dut (
      .clk_i      (clk),
      .arstn_i    (arstn),
      .spi_clk_o  (sclk[g]),
      .spi_cs_o   (cs[g]),
      .spi_mosi_o (mosi[g]),
      .spi_miso_i (miso[g]),
      .s_axis     (s_if),
      .m_axis     (m_if)
    );

    logic [7:0] stx;
    logic [7:0] srx;
    logic       smiso = 1'b0;
    logic       mosi_neg;
    logic       mosi_smp;
    logic       smp_pend = 1'b0;
    logic       lead;
    logic       prev_ok = 1'b0;
    int         nedge  = 0;
    int         lowcnt = 0;
    int         gapcnt = 0;

    assign miso[g] = tie_en ? tie_val : smiso;

    always @(negedge clk) begin
      if (smp_pend) begin
        smp_pend = 1'b0;
        chk($sformatf("mosi_stable_m%0d", g), mosi[g], mosi_smp);
      end
      mosi_neg = mosi[g];
      if (cs[g]) gapcnt++;
      else lowcnt++;
      if (arstn && m_tvalid[g] && m_tready) begin
        if (exp_m[g].size() != 0)
          chk($sformatf("m_rx_m%0d", g), m_tdata[g], exp_m[g].pop_front());
        else
          chk($sformatf("m_unexpected_m%0d", g), exp_m[g].size(), 1);
      end
    end

    always @(negedge cs[g]) begin
      if (arstn) begin
        chk($sformatf("sclk_idle_pre_m%0d", g), sclk[g], POL);
        if (prev_ok)
          chk($sformatf("cs_gap_m%0d", g), gapcnt >= DIV, 1);
        lowcnt = 0;
        nedge  = 0;
        srx    = '0;
        if (stx_q[g].size() != 0) begin
          stx = stx_q[g].pop_front();
        end else begin
          chk($sformatf("slave_word_m%0d", g), stx_q[g].size(), 1);
          stx = '0;
        end
        if (!PHA) begin
          smiso = stx[7];
          stx   = {stx[6:0], 1'b0};
        end
      end
    end

    // slave samples on the edge selected by CPHA and drives on the other
    always @(sclk[g]) begin
      if (arstn && cs[g] === 1'b0) begin
        nedge++;
        lead = nedge[0];
        if (lead != PHA) begin
          srx      = {srx[6:0], mosi_neg};
          mosi_smp = mosi_neg;
          smp_pend = 1'b1;
        end else begin
          smiso = stx[7];
          stx   = {stx[6:0], 1'b0};
        end
      end
    end

    always @(posedge cs[g]) begin
      if (arstn === 1'b1) begin
        chk($sformatf("cs_low_m%0d", g), lowcnt, FRAME);
        chk($sformatf("edges_m%0d", g), nedge, 2 * N);
        chk($sformatf("sclk_idle_post_m%0d", g), sclk[g], POL);
        if (exp_s[g].size() != 0)
          chk($sformatf("s_rx_m%0d", g), srx, exp_s[g].pop_front());
        else
          chk($sformatf("s_unexpected_m%0d", g), exp_s[g].size(), 1);
        prev_ok = 1'b1;
      end else begin
        prev_ok = 1'b0;
      end
      gapcnt = 0;
    end
  end

  task automatic offer(input logic [7:0] w, input logic [7:0] sw);
    for (int i = 0; i < 4; i++) begin
      stx_q[i].push_back(sw);
      exp_s[i].push_back(w);
      exp_m[i].push_back(tie_en ? {8{tie_val}} : sw);
    end
    s_tdata  = w;
    s_tvalid = 1'b1;
  endtask

  task automatic wait_hs();
    int n = 0;
    @(negedge clk);
    while (!s_tready[1] && n < BUD) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_wait", n < BUD, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w, input logic [7:0] sw);
    offer(w, sw);
    wait_hs();
  endtask

  function automatic bit busy();
    bit b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (exp_m[i].size() != 0 || exp_s[i].size() != 0 || cs[i] !== 1'b1)
        b = 1'b1;
    end
    return b;
  endfunction

  task automatic drain();
    int n = 0;
    while (n < 3000 && busy()) begin
      @(negedge clk);
      n++;
    end
    chk("drain", n < 3000, 1);
  endtask

  initial begin
    int  n;
    bit  seen;
    arstn    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    tie_en   = 1'b0;
    tie_val  = 1'b0;
    #1 arstn = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_cs_m%0d", i), cs[i], 1);
      chk($sformatf("rst_sclk_m%0d", i), sclk[i], i >= 2);
      chk($sformatf("rst_mosi_m%0d", i), mosi[i], 0);
      chk($sformatf("rst_mtvalid_m%0d", i), m_tvalid[i], 0);
      chk($sformatf("rst_mtdata_m%0d", i), m_tdata[i], 0);
      chk($sformatf("rst_stready_m%0d", i), s_tready[i], 0);
    end
    @(posedge clk);
    #1 arstn = 1'b1;

    // single word, all modes
    send(8'hA5, 8'h3C);
    s_tvalid = 1'b0;
    drain();

    // rx slot full blocks the next word
    m_tready = 1'b0;
    send(8'h11, 8'hAA);
    offer(8'h22, 8'hBB);
    n = 0;
    while (!m_tvalid[1] && n < BUD) begin
      @(negedge clk);
      n++;
    end
    chk("mtvalid_wait", n < BUD, 1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (s_tready[1] !== 1'b0) seen = 1'b1;
    end
    chk("stready_blocked", seen, 0);
    chk("cs_idle_blocked", cs[1], 1);
    chk("mtdata_held", m_tdata[1], 8'hAA);
    @(posedge clk);
    #1 m_tready = 1'b1;
    wait_hs();
    s_tvalid = 1'b0;
    drain();

    // continuous stream
    for (int w = 1; w <= 4; w++) begin
      send(8'(w), 8'hC0 | 8'(w));
    end
    s_tvalid = 1'b0;
    drain();

    // reset in the middle of a frame
    send(8'h77, 8'h66);
    s_tvalid = 1'b0;
    n = 0;
    while (gi[1].nedge < 7 && n < BUD) begin
      @(negedge clk);
      n++;
    end
    chk("edge7_wait", n < BUD, 1);
    @(posedge clk);
    #1 arstn = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort_cs_m%0d", i), cs[i], 1);
      chk($sformatf("abort_sclk_m%0d", i), sclk[i], i >= 2);
      chk($sformatf("abort_mtvalid_m%0d", i), m_tvalid[i], 0);
      exp_m[i].delete();
      exp_s[i].delete();
      stx_q[i].delete();
    end
    repeat (2) @(posedge clk);
    #1 arstn = 1'b1;
    send(8'h5A, 8'h96);
    s_tvalid = 1'b0;
    drain();

    // constant MISO levels
    tie_en  = 1'b1;
    tie_val = 1'b1;
    send(8'h00, 8'h5A);
    s_tvalid = 1'b0;
    drain();
    tie_val = 1'b0;
    send(8'hFF, 8'h5A);
    s_tvalid = 1'b0;
    drain();
    tie_en = 1'b0;

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("left_m_m%0d", i), exp_m[i].size(), 0);
      chk($sformatf("left_s_m%0d", i), exp_s[i].size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
